// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: branch-type encodings,
// the 2-bit counter reset value and the counter training helper.
package branch_predict_unit_pkg;

  typedef enum logic [2:0] {
    BR_NOBRANCH = 3'd0,
    BR_BEQ      = 3'd1,
    BR_BNE      = 3'd2,
    BR_BLT      = 3'd3,
    BR_BGE      = 3'd4,
    BR_BLTU     = 3'd5,
    BR_BGEU     = 3'd6
  } br_type_e;

  // Weakly not-taken: one taken outcome flips the prediction to taken.
  localparam logic [1:0] CNT_RESET = 2'b01;

  // Saturating 2-bit counter step: up on taken, down on not-taken.
  function automatic logic [1:0] cnt_train(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_unit_branch_cond.sv
// branch_cond: combinational RV32I conditional-branch evaluation.
// NOBRANCH and unused encodings always resolve not-taken.
module branch_cond
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] reg1,
  input  logic [XLEN-1:0] reg2,
  input  logic [2:0]      br_type,
  output logic            taken
);

  // Compare operands according to the branch type.
  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken = (reg1 == reg2);
      BR_BNE:  taken = (reg1 != reg2);
      BR_BLT:  taken = ($signed(reg1) <  $signed(reg2));
      BR_BGE:  taken = ($signed(reg1) >= $signed(reg2));
      BR_BLTU: taken = (reg1 <  reg2);
      BR_BGEU: taken = (reg1 >= reg2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit counters feeding IF,
// EX-stage branch resolution with mispredict redirect, table training and
// saturating branch/mispredict statistics.
// Optional feature macro: BPU_GSHARE_EN (counters indexed by PC xor global
// history); the default build uses purely PC-indexed counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10,
  parameter int GHR_W   = 6,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [XLEN-1:0]  if_pred_target,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [2:0]       ex_br_type,
  input  logic [XLEN-1:0]  ex_reg1,
  input  logic [XLEN-1:0]  ex_reg2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_br_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             ex_taken,
  output logic             ex_is_branch,
  output logic             ex_redirect,
  output logic [XLEN-1:0]  ex_redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int              IDX_W   = $clog2(ENTRIES);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic             valid_r [ENTRIES];
  logic [TAG_W-1:0] tag_r   [ENTRIES];
  logic [XLEN-1:0]  tgt_r   [ENTRIES];
  logic [1:0]       cnt_r   [ENTRIES];

  logic [CNT_W-1:0] stat_branches_r;
  logic [CNT_W-1:0] stat_mispredicts_r;

  logic [IDX_W-1:0] if_idx_s;
  logic [IDX_W-1:0] if_cidx_s;
  logic [TAG_W-1:0] if_tag_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic [IDX_W-1:0] ex_cidx_s;
  logic [TAG_W-1:0] ex_tag_s;
  logic             if_hit_s;
  logic             cond_taken_s;
  logic             update_s;

  assign if_idx_s = if_pc[IDX_W+1:2];
  assign if_tag_s = if_pc[IDX_W+2 +: TAG_W];
  assign ex_idx_s = ex_pc[IDX_W+1:2];
  assign ex_tag_s = ex_pc[IDX_W+2 +: TAG_W];
  assign update_s = ex_valid & ~ex_stall;

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] ghr_r;

  // Counter index mixes in the global history; BTB fields stay PC-indexed.
  assign if_cidx_s = if_idx_s ^ IDX_W'(ghr_r);
  assign ex_cidx_s = ex_idx_s ^ IDX_W'(ghr_r);

  // Global history shifts in each trained branch outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_r <= {GHR_W{1'b0}};
    end else if (update_s && ex_is_branch) begin
      ghr_r <= {ghr_r[GHR_W-2:0], ex_taken};
    end
  end
`else
  assign if_cidx_s = if_idx_s;
  assign ex_cidx_s = ex_idx_s;
`endif

  branch_cond #(
    .XLEN(XLEN)
  ) u_branch_cond (
    .reg1    (ex_reg1),
    .reg2    (ex_reg2),
    .br_type (ex_br_type),
    .taken   (cond_taken_s)
  );

  // Fetch-side lookup from registered table state.
  always_comb begin
    if_hit_s       = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
    if_pred_taken  = 1'b0;
    if_pred_target = if_pc + PC_STEP;
    if (if_hit_s && cnt_r[if_cidx_s][1]) begin
      if_pred_taken  = 1'b1;
      if_pred_target = tgt_r[if_idx_s];
    end else begin
      if_pred_taken  = 1'b0;
      if_pred_target = if_pc + PC_STEP;
    end
  end

  // EX resolution and mispredict detection; a predicted-taken non-branch
  // falls out of the taken/pred_taken disagreement.
  always_comb begin
    ex_is_branch   = ex_valid && (ex_br_type != BR_NOBRANCH);
    ex_taken       = ex_valid && cond_taken_s;
    ex_redirect_pc = ex_taken ? ex_br_target : (ex_pc + PC_STEP);
    ex_redirect    = 1'b0;
    if (!ex_valid) begin
      ex_redirect = 1'b0;
    end else if (ex_taken != ex_pred_taken) begin
      ex_redirect = 1'b1;
    end else if (ex_taken && (ex_pred_target != ex_br_target)) begin
      ex_redirect = 1'b1;
    end else begin
      ex_redirect = 1'b0;
    end
  end

  // Train counters, allocate on taken branches, evict aliased entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        tag_r[i]   <= {TAG_W{1'b0}};
        tgt_r[i]   <= {XLEN{1'b0}};
        cnt_r[i]   <= CNT_RESET;
      end
    end else if (update_s) begin
      if (ex_is_branch) begin
        cnt_r[ex_cidx_s] <= cnt_train(cnt_r[ex_cidx_s], ex_taken);
        if (ex_taken) begin
          valid_r[ex_idx_s] <= 1'b1;
          tag_r[ex_idx_s]   <= ex_tag_s;
          tgt_r[ex_idx_s]   <= ex_br_target;
        end
      end else if (ex_pred_taken) begin
        valid_r[ex_idx_s] <= 1'b0;
      end
    end
  end

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_r    <= {CNT_W{1'b0}};
      stat_mispredicts_r <= {CNT_W{1'b0}};
    end else if (update_s) begin
      if (ex_is_branch && (stat_branches_r != {CNT_W{1'b1}})) begin
        stat_branches_r <= stat_branches_r + CNT_W'(1'b1);
      end
      if (ex_redirect && (stat_mispredicts_r != {CNT_W{1'b1}})) begin
        stat_mispredicts_r <= stat_mispredicts_r + CNT_W'(1'b1);
      end
    end
  end

  assign stat_branches    = stat_branches_r;
  assign stat_mispredicts = stat_mispredicts_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the
// predictor tables and statistics.
module tb_branch_predict_unit;

  localparam int ENT   = 64;
  localparam int IDX_W = 6;
  localparam int TAG_W = 10;
  localparam int GHR_W = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid;
  logic        ex_stall;
  logic [2:0]  ex_br_type;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [31:0] ex_pc;
  logic [31:0] ex_br_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_taken;
  logic        ex_is_branch;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int n_vec  = 0;
  int n_fail = 0;

  // Model state
  bit          m_valid [ENT];
  int          m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_cnt   [ENT];
  int          m_ghr;
  longint      m_branches;
  longint      m_mis;

  branch_predict_unit dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .if_pred_target   (if_pred_target),
    .ex_valid         (ex_valid),
    .ex_stall         (ex_stall),
    .ex_br_type       (ex_br_type),
    .ex_reg1          (ex_reg1),
    .ex_reg2          (ex_reg2),
    .ex_pc            (ex_pc),
    .ex_br_target     (ex_br_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_taken         (ex_taken),
    .ex_is_branch     (ex_is_branch),
    .ex_redirect      (ex_redirect),
    .ex_redirect_pc   (ex_redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'd0;
      m_cnt[i]   = 1;
    end
    m_ghr      = 0;
    m_branches = 0;
    m_mis      = 0;
  endfunction

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic int pc_tag(input logic [31:0] pc);
    return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
  endfunction

  function automatic int cnt_idx(input logic [31:0] pc);
`ifdef BPU_GSHARE_EN
    return pc_idx(pc) ^ m_ghr;
`else
    return pc_idx(pc);
`endif
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output bit pt, output logic [31:0] tg);
    int i;
    i  = pc_idx(pc);
    pt = m_valid[i] && (m_tag[i] == pc_tag(pc)) && (m_cnt[cnt_idx(pc)] >= 2);
    tg = pt ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void model_resolve(output bit t, output bit br, output bit red, output logic [31:0] rpc);
    bit c;
    case (ex_br_type)
      3'd1:    c = (ex_reg1 == ex_reg2);
      3'd2:    c = (ex_reg1 != ex_reg2);
      3'd3:    c = ($signed(ex_reg1) <  $signed(ex_reg2));
      3'd4:    c = ($signed(ex_reg1) >= $signed(ex_reg2));
      3'd5:    c = (ex_reg1 <  ex_reg2);
      3'd6:    c = (ex_reg1 >= ex_reg2);
      default: c = 1'b0;
    endcase
    t   = ex_valid && c;
    br  = ex_valid && (ex_br_type != 3'd0);
    red = ex_valid && ((t != ex_pred_taken) || (t && (ex_pred_target != ex_br_target)));
    rpc = t ? ex_br_target : ex_pc + 32'd4;
  endfunction

  function automatic void model_update();
    bit t, br, red;
    logic [31:0] rpc;
    int ci, i;
    model_resolve(t, br, red, rpc);
    if (!(ex_valid && !ex_stall)) return;
    i  = pc_idx(ex_pc);
    ci = cnt_idx(ex_pc);
    if (br) begin
      m_cnt[ci] = t ? ((m_cnt[ci] < 3) ? m_cnt[ci] + 1 : 3) : ((m_cnt[ci] > 0) ? m_cnt[ci] - 1 : 0);
      if (t) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = pc_tag(ex_pc);
        m_tgt[i]   = ex_br_target;
      end
      m_branches++;
      m_ghr = ((m_ghr << 1) | int'(t)) % (1 << GHR_W);
    end else if (ex_pred_taken) begin
      m_valid[i] = 1'b0;
    end
    if (red) m_mis++;
  endfunction

  task automatic check_outputs();
    bit pt, t, br, red;
    logic [31:0] tg, rpc;
    model_lookup(if_pc, pt, tg);
    model_resolve(t, br, red, rpc);
    check("if_pred_taken",  if_pred_taken,  pt);
    check("if_pred_target", if_pred_target, tg);
    check("ex_taken",       ex_taken,       t);
    check("ex_is_branch",   ex_is_branch,   br);
    check("ex_redirect",    ex_redirect,    red);
    check("ex_redirect_pc", ex_redirect_pc, rpc);
    check("stat_branches",  stat_branches,  m_branches);
    check("stat_mispred",   stat_mispredicts, m_mis);
  endtask

  // Called just after a rising edge: drive, check mid-cycle, clock, update model.
  task automatic apply(input bit v, input bit st, input logic [2:0] ty,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input bit pt, input logic [31:0] ptgt, input logic [31:0] ipc);
    ex_valid = v; ex_stall = st; ex_br_type = ty; ex_reg1 = r1; ex_reg2 = r2;
    ex_pc = pc; ex_br_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    if_pc = ipc;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input logic [31:0] ipc);
    apply(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, ipc);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = 32'h100 + 32'(4 * $urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) pc = pc + 32'h1000;
    return pc;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return $urandom;
      default: return 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    longint mis_before;
    bit pt;
    logic [31:0] tg, pc, tgt;

    rst = 1'b1;
    ex_valid = 1'b0; ex_stall = 1'b0; ex_br_type = 3'd0; ex_reg1 = 32'd0; ex_reg2 = 32'd0;
    ex_pc = 32'd0; ex_br_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
    if_pc = 32'h100;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    check("reset_pred_taken",  if_pred_taken,  1'b0);
    check("reset_pred_target", if_pred_target, 32'h104);
    check("reset_stat_br",     stat_branches,  32'd0);
    idle(32'h100);

    // Allocation and training: BEQ taken, predicted not-taken
    apply(1'b1, 1'b0, 3'd1, 32'd5, 32'd5, 32'h100, 32'h80, 1'b0, 32'h104, 32'h100);
    check("beq_redirect",    ex_redirect,    1'b1);
    check("beq_redirect_pc", ex_redirect_pc, 32'h80);
    idle(32'h100);

    // Signed vs unsigned compare
    apply(1'b1, 1'b0, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, 32'h204, 32'h200);
    check("blt_taken", ex_taken, 1'b1);
    apply(1'b1, 1'b0, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b0, 32'h304, 32'h300);
    check("bltu_taken", ex_taken, 1'b0);

    // Saturation: four taken, then two not-taken at 0x100
    repeat (4) apply(1'b1, 1'b0, 3'd1, 32'd5, 32'd5, 32'h100, 32'h80, 1'b1, 32'h80, 32'h100);
    repeat (2) begin
      apply(1'b1, 1'b0, 3'd1, 32'd5, 32'd6, 32'h100, 32'h80, 1'b1, 32'h80, 32'h100);
      idle(32'h100);
    end

    // Re-allocate, then alias eviction by a non-branch predicted taken
    repeat (2) apply(1'b1, 1'b0, 3'd1, 32'd1, 32'd1, 32'h100, 32'h80, 1'b0, 32'h104, 32'h100);
    apply(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h100, 32'h0, 1'b1, 32'h80, 32'h100);
    check("alias_redirect",    ex_redirect,    1'b1);
    check("alias_redirect_pc", ex_redirect_pc, 32'h104);
    idle(32'h100);

    // Stall suppresses update: mispredicting branch held three cycles
    mis_before = m_mis;
    repeat (3) apply(1'b1, 1'b1, 3'd2, 32'd1, 32'd2, 32'h140, 32'h20, 1'b0, 32'h144, 32'h140);
    check("stall_hold_mis", stat_mispredicts, mis_before);
    apply(1'b1, 1'b0, 3'd2, 32'd1, 32'd2, 32'h140, 32'h20, 1'b0, 32'h144, 32'h140);
    check("stall_release_mis", stat_mispredicts, mis_before + 1);

    // Randomized traffic with a mid-run reset
    for (int n = 0; n < 1500; n++) begin
      if (n == 750) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_stat_br",  stat_branches,    32'd0);
        check("midrst_stat_mis", stat_mispredicts, 32'd0);
        check("midrst_pred",     if_pred_taken,    1'b0);
        @(negedge clk);
        rst = 1'b0;
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      pc  = rand_pc();
      tgt = 32'h40 + 32'(4 * $urandom_range(0, 7));
      model_lookup(pc, pt, tg);
      if ($urandom_range(0, 4) == 0) begin
        pt = 1'($urandom_range(0, 1));
        tg = pt ? tgt : pc + 32'd4;
      end
      apply(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)), rand_op(), rand_op(), pc, tgt, pt, tg, rand_pc());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
